user_dma_mm2s_axi_reader: RTL

//  AXI4 memory-mapped read engine that feeds the MM2S stream stage. On start it reads
//  MM_count beats from memory at src_addr using INCR bursts, and writes every returned

---
 rtl/user_dma_mm2s_axi_reader.sv | 107 ++++++++++
 1 files changed

// File: rtl/user_dma_mm2s_axi_reader.sv
// user_dma_mm2s_axi_reader: AXI4 INCR burst reader feeding the MM2S FIFO, one burst outstanding,
// bursts clipped to BURST_LEN, remaining beats and the next 4KB boundary.
module user_dma_mm2s_axi_reader #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] src_addr,
  input  logic [23:0]                   MM_count,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] MM_data,
  output logic                          rnext,
  input  logic                          fifo_mm2s_full,
  input  logic                          fifo_mm2s_almost_full
);
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int BPB = C_M_AXI_DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, DONE} state_t;
  state_t        state;
  logic [AW-1:0] addr;
  logic [23:0]   remaining;
  logic [8:0]    len_q, beat_cnt, len;
  logic [12:0]   bnd;
  logic [24:0]   l1, l2;
  wire           unused_rlast = M_AXI_RLAST;
  assign M_AXI_ARSIZE  = 3'(SZ);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_RREADY  = (state == DATA) & ~fifo_mm2s_full;
  assign rnext         = M_AXI_RVALID & M_AXI_RREADY;
  assign MM_data       = M_AXI_RDATA;
  // Burst length: smallest of max burst, beats left, and beats up to the next 4KB page.
  always_comb begin
    bnd = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
    l1  = ({1'b0, remaining} < 25'(C_M_AXI_BURST_LEN)) ? {1'b0, remaining} : 25'(C_M_AXI_BURST_LEN);
    l2  = (25'(bnd) < l1) ? 25'(bnd) : l1;
    len = 9'(l2);
  end
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      addr          <= '0;
      remaining     <= '0;
      len_q         <= '0;
      beat_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr      <= src_addr & ~AW'(BPB - 1);
          remaining <= MM_count;
          err       <= 1'b0;
          busy      <= 1'b1;
          state     <= (MM_count == 24'd0) ? DONE : WAIT;
        end
        WAIT: if (!fifo_mm2s_almost_full) begin
          len_q         <= len;
          M_AXI_ARADDR  <= addr;
          M_AXI_ARLEN   <= 8'(len - 9'd1);
          M_AXI_ARVALID <= 1'b1;
          state         <= ADDR;
        end
        ADDR: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          beat_cnt      <= len_q;
          state         <= DATA;
        end
        DATA: if (rnext) begin
          beat_cnt  <= beat_cnt - 9'd1;
          remaining <= remaining - 24'd1;
          err       <= err | (M_AXI_RRESP != 2'b00);
          if (beat_cnt == 9'd1) begin
            addr  <= addr + (AW'(len_q) << SZ);
            state <= (remaining == 24'd1) ? DONE : WAIT;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
